apb_requester: RTL and testbench
================================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, the APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of ACCESS cycles; it is only used when APB_REQ_TIMEOUT_EN is defined.
REQ-004 SHALL have ports, one per line as `name  direction  width  meaning`:
- clk  input  1  the single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid_i  input  1  a command is offered.
- cmd_ready_o  output  1  a command is accepted when valid and ready are both high at a rising edge.
- cmd_write_i  input  1  1 = write, 0 = read.
- cmd_addr_i  input  ADDR_W  command address.
- cmd_wdata_i  input  DATA_W  write data.
- rsp_valid_o  output  1  one-cycle completion pulse.
- rsp_rdata_o  output  DATA_W  read data; 0 for writes.
- rsp_timeout_o  output  1  completion was a timeout abort; qualified by rsp_valid_o.
- psel_o, penable_o, pwrite_o  output  1 each  APB control.
- paddr_o  output  ADDR_W  APB address.
- pwdata_o  output  DATA_W  APB write data.
- prdata_i  input  DATA_W  APB read data.
- pready_i  input  1  APB ready.

Function
REQ-005 SHALL implement the APB requester FSM with states IDLE, SETUP and ACCESS.
REQ-006 IDLE: psel_o=0, penable_o=0, cmd_ready_o=1; an accepted command SHALL register cmd_write_i, cmd_addr_i and cmd_wdata_i onto pwrite_o, paddr_o and pwdata_o and go to SETUP.
REQ-007 SETUP SHALL last exactly one cycle with psel_o=1, penable_o=0 and cmd_ready_o=0, then go to ACCESS.
REQ-008 ACCESS SHALL drive psel_o=1, penable_o=1 and hold there while pready_i=0.
REQ-009 paddr_o, pwrite_o and pwdata_o SHALL remain stable from SETUP through the final ACCESS cycle, and SHALL hold their last value in IDLE.
REQ-010 In ACCESS with pready_i=1, cmd_ready_o SHALL be 1 (combinational from pready_i).
- If cmd_valid_i=1 in that cycle, the new command SHALL be captured and the next state SHALL be SETUP; this is back-to-back operation with psel_o staying high.
- Otherwise the next state SHALL be IDLE.
REQ-011 In ACCESS cycles with pready_i=0, cmd_ready_o SHALL be 0.
REQ-012 On a completing edge (ACCESS and pready_i=1), the block SHALL, in the following cycle:
- pulse rsp_valid_o for exactly one cycle;
- drive rsp_rdata_o = prdata_i as sampled for a read, or 0 for a write;
- drive rsp_timeout_o = 0.
REQ-013 Minimum latency SHALL be 2 cycles from command acceptance to the completing edge, and 3 cycles to rsp_valid_o; back-to-back throughput SHALL be one transfer per 2 cycles.
REQ-014 rsp_valid_o SHALL have no backpressure; the consumer always accepts it.
REQ-015 pready_i and prdata_i SHALL be ignored outside ACCESS.

Reset
REQ-016 Asserting reset SHALL immediately force the following, with no clock edge needed:
- state=IDLE;
- psel_o, penable_o, pwrite_o and rsp_valid_o to 0;
- paddr_o, pwdata_o and rsp_rdata_o to 0;
- rsp_timeout_o to 0.
REQ-017 Reset in SETUP or ACCESS SHALL abort the transfer silently, with no rsp_valid_o for it after deassertion.
REQ-018 cmd_ready_o SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-019 With APB_REQ_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles.
- If pready_i is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, the next state SHALL be IDLE (psel_o=0, penable_o=0).
- In that next cycle rsp_valid_o=1, rsp_timeout_o=1 and rsp_rdata_o=0.
- No command SHALL be accepted on the abort edge.
- The counter SHALL clear on entry to SETUP.
REQ-020 Without APB_REQ_TIMEOUT_EN, ACCESS SHALL wait indefinitely, rsp_timeout_o SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-021 Package apb_requester_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS) and the default width and timeout constants.
REQ-022 The timeout counter SHALL be sub-module apb_requester_timer, instantiated only under APB_REQ_TIMEOUT_EN.

Verification
REQ-023 Write to 0x0000_0010 with data 0xDEAD_BEEF, pready_i=1 immediately: expect psel_o high for 2 cycles, penable_o only in the 2nd, and rsp_valid_o one cycle later with rsp_rdata_o=0.
REQ-024 Read from 0x0000_0004 with prdata_i=0x1234_5678 and pready_i low for 3 ACCESS cycles: expect penable_o high for 4 cycles, paddr_o stable throughout, and rsp_rdata_o=0x1234_5678.
REQ-025 Two commands offered with cmd_valid_i held high: expect the second SETUP to directly follow the first completing ACCESS, psel_o continuous for 4 cycles, and two rsp_valid_o pulses 2 cycles apart.
REQ-026 Reset asserted in the 2nd ACCESS cycle of a read: expect psel_o and penable_o low in that same cycle, no rsp_valid_o, and cmd_ready_o=1 after release.
REQ-027 With APB_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready_i held at 0: expect penable_o for exactly 4 cycles, then rsp_valid_o=1 with rsp_timeout_o=1.
REQ-028 Without the macro and pready_i=0 for 100 cycles: expect penable_o held high and no rsp_valid_o; after pready_i rises, a normal completion.

Source files
------------

// File: rtl/apb_requester_pkg.sv
// Shared types and default constants for the APB requester.
package apb_requester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_requester_timer.sv
// ACCESS-cycle counter for the APB requester timeout abort.
// Only instantiated when APB_REQ_TIMEOUT_EN is defined.
module apb_requester_timer
  import apb_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of ACCESS cycles already spent, so the
  // TIMEOUT_CYCLES-th ACCESS cycle sees cnt == TIMEOUT_CYCLES-1.
  assign expired = en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles; cleared whenever a new transfer enters SETUP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB requester: turns a valid/ready command stream into APB transfers
// and returns a one-cycle completion pulse with read data.
// Optional feature macro: APB_REQ_TIMEOUT_EN (abort ACCESS after
// TIMEOUT_CYCLES wait states, reported through rsp_timeout_o).
module apb_requester
  import apb_requester_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);

  state_t state, next_state;
  logic   accept;
  logic   complete;
  logic   abort;

`ifdef APB_REQ_TIMEOUT_EN
  logic expired;

  apb_requester_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (next_state == SETUP),
    .en     (state == ACCESS),
    .expired(expired)
  );
`else
  // TIMEOUT_CYCLES only matters when the timer is built.
  if (TIMEOUT_CYCLES > 0) begin : g_no_timer
  end
`endif

  // APB control follows the state directly, so reset drops it at once.
  assign psel_o    = (state != IDLE);
  assign penable_o = (state == ACCESS);
  assign accept    = cmd_valid_i && cmd_ready_o;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, command handshake and completion decode.
  always_comb begin
    next_state  = state;
    cmd_ready_o = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) next_state = SETUP;
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          // Ready is combinational from pready_i so a waiting command
          // can follow straight into SETUP without an IDLE bubble.
          cmd_ready_o = 1'b1;
          complete    = 1'b1;
          next_state  = cmd_valid_i ? SETUP : IDLE;
        end
`ifdef APB_REQ_TIMEOUT_EN
        else if (expired) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
`endif
      end
      default: next_state = IDLE;
    endcase
  end

  // APB address/data/direction captured on acceptance, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
    end else if (accept) begin
      pwrite_o <= cmd_write_i;
      paddr_o  <= cmd_addr_i;
      pwdata_o <= cmd_wdata_i;
    end
  end

  // Completion pulse and read data, one cycle after the finishing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= complete || abort;
      rsp_rdata_o <= (complete && !pwrite_o) ? prdata_i : '0;
    end
  end

`ifdef APB_REQ_TIMEOUT_EN
  // Flag the completion that was produced by a timeout abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_timeout_o <= 1'b0;
    end else begin
      rsp_timeout_o <= abort;
    end
  end
`else
  assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a response scoreboard.
// Timeout scenario built only with APB_REQ_TIMEOUT_EN; the unbounded
// wait scenario only without it.
module tb_apb_requester;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  typedef struct packed {
    logic        timeout;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  apb_requester #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_wdata_i  (cmd_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_timeout_o(rsp_timeout),
    .psel_o       (psel),
    .penable_o    (penable),
    .pwrite_o     (pwrite),
    .paddr_o      (paddr),
    .pwdata_o     (pwdata),
    .prdata_i     (prdata),
    .pready_i     (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_timeout", rsp_timeout, e.timeout);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    reset  = 1'b1;
    prdata = '0;
    pready = 1'b0;
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);

    // ---- single write, zero wait states ----
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    pready = 1'b1;
    exp_q.push_back('{timeout: 1'b0, rdata: 32'h0});
    #1;
    check("wr_idle_ready", cmd_ready, 1);
    check("wr_idle_psel", psel, 0);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_ready", cmd_ready, 0);
    check("wr_paddr", paddr, 32'h0000_0010);
    check("wr_pwdata", pwdata, 32'hDEAD_BEEF);
    check("wr_pwrite", pwrite, 1);
    @(negedge clk);
    #1;
    check("wr_access_psel", psel, 1);
    check("wr_access_penable", penable, 1);
    check("wr_access_ready", cmd_ready, 1);
    check("wr_access_rsp", rsp_valid, 0);
    @(negedge clk);
    #1;
    check("wr_done_psel", psel, 0);
    check("wr_rsp_valid", rsp_valid, 1);
    @(negedge clk);
    #1;
    check("wr_rsp_pulse_end", rsp_valid, 0);
    check("wr_idle_paddr_hold", paddr, 32'h0000_0010);

    // ---- read with three wait states ----
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    pready = 1'b0;
    prdata = 32'h1234_5678;
    exp_q.push_back('{timeout: 1'b0, rdata: 32'h1234_5678});
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rd_setup_penable", penable, 0);
    check("rd_setup_pwrite", pwrite, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pready = (i == 3);
      #1;
      check("rd_access_penable", penable, 1);
      check("rd_access_paddr", paddr, 32'h0000_0004);
      check("rd_access_ready", cmd_ready, (i == 3));
      check("rd_access_rsp", rsp_valid, 0);
    end
    @(negedge clk);
    pready = 1'b0;
    #1;
    check("rd_done_penable", penable, 0);
    check("rd_rsp_valid", rsp_valid, 1);

    // ---- back-to-back write then read ----
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111);
    pready = 1'b1;
    exp_q.push_back('{timeout: 1'b0, rdata: 32'h0});
    #1;
    check("b2b_rsp_idle", rsp_valid, 0);
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 32'h0000_0024, 32'h0);
    prdata = 32'hCAFE_F00D;
    exp_q.push_back('{timeout: 1'b0, rdata: 32'hCAFE_F00D});
    #1;
    check("b2b_setup1_psel", psel, 1);
    check("b2b_setup1_penable", penable, 0);
    check("b2b_setup1_paddr", paddr, 32'h0000_0020);
    @(negedge clk);
    #1;
    check("b2b_access1_penable", penable, 1);
    check("b2b_access1_ready", cmd_ready, 1);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("b2b_setup2_psel", psel, 1);
    check("b2b_setup2_penable", penable, 0);
    check("b2b_setup2_paddr", paddr, 32'h0000_0024);
    check("b2b_setup2_pwrite", pwrite, 0);
    check("b2b_rsp1", rsp_valid, 1);
    @(negedge clk);
    #1;
    check("b2b_access2_psel", psel, 1);
    check("b2b_access2_penable", penable, 1);
    check("b2b_gap", rsp_valid, 0);
    @(negedge clk);
    pready = 1'b0;
    #1;
    check("b2b_done_psel", psel, 0);
    check("b2b_rsp2", rsp_valid, 1);

    // ---- reset during the second ACCESS cycle of a read ----
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    prdata = 32'h5555_AAAA;
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check("rstx_access1_penable", penable, 1);
    @(negedge clk);
    check("rstx_access2_penable", penable, 1);
    reset = 1'b1;
    #1;
    check("rstx_psel", psel, 0);
    check("rstx_penable", penable, 0);
    check("rstx_paddr", paddr, 0);
    @(negedge clk);
    reset  = 1'b0;
    pready = 1'b1;
    #1;
    check("rstx_cmd_ready", cmd_ready, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0 || psel !== 1'b0) bad++;
    end
    check("rstx_silent", bad, 0);
    pready = 1'b0;

`ifdef APB_REQ_TIMEOUT_EN
    // ---- timeout abort after four ACCESS cycles ----
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 32'h0000_0030, 32'h0);
    prdata = 32'hFFFF_0000;
    exp_q.push_back('{timeout: 1'b1, rdata: 32'h0});
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) drive_cmd(1'b1, 1'b1, 32'h0000_0099, 32'h0);
      #1;
      check("to_access_penable", penable, 1);
      check("to_access_ready", cmd_ready, 0);
    end
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("to_abort_psel", psel, 0);
    check("to_abort_penable", penable, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_paddr_kept", paddr, 32'h0000_0030);
    @(negedge clk);
    #1;
    check("to_rsp_end", rsp_valid, 0);
`else
    // ---- unbounded wait, then normal completion ----
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    prdata = 32'hA5A5_A5A5;
    exp_q.push_back('{timeout: 1'b0, rdata: 32'hA5A5_A5A5});
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 32'h0, 32'h0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (penable !== 1'b1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) bad++;
    end
    check("wait_held", bad, 0);
    @(negedge clk);
    pready = 1'b1;
    #1;
    check("wait_final_penable", penable, 1);
    check("wait_final_ready", cmd_ready, 1);
    @(negedge clk);
    pready = 1'b0;
    #1;
    check("wait_rsp_valid", rsp_valid, 1);
    check("wait_rsp_timeout", rsp_timeout, 0);
`endif

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
